cic_interp_core: RTL

- N-stage CIC interpolator for the transmit (DUC) path, the mirror of the receive-side CIC decimator.
- Comb (differentiator) section runs on the low-rate input strobe; integrator section runs on the high-rate output strobe, with zero-stuffing between input samples.
- Output is renormalised by a rate-dependent shift and clipped to bw bits.
- Feeds the DAC-side halfband/CORDIC chain.

---
 rtl/cic_interp_core.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/cic_interp_core.sv
// N-stage CIC interpolator: comb section on the low-rate strobe, zero-stuffed integrators on the
// high-rate strobe, rate-dependent renormalising shift and bw-bit clip. Define CIC_INTERP_ROUND_EN for round-half-up.
module cic_interp_core #(
  parameter int bw               = 16,
  parameter int N                = 4,
  parameter int log2_of_max_rate = 7
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 enable,
  input  logic [7:0]           rate,
  input  logic                 strobe_in,
  input  logic                 strobe_out,
  input  logic signed [bw-1:0] signal_in,
  output logic signed [bw-1:0] signal_out,
  output logic                 strobe_valid
);

  localparam int W  = bw + N*log2_of_max_rate;
  localparam int SW = $clog2(W+1);
  localparam logic signed [W:0] SAT_MAX = {{(W+2-bw){1'b0}}, {(bw-1){1'b1}}};
  localparam logic signed [W:0] SAT_MIN = {{(W+2-bw){1'b1}}, {(bw-1){1'b0}}};

  // (N-1)*ceil(log2(R)), with R of 0/1 giving 0 and oversized R clamped to the max rate.
  function automatic logic [SW-1:0] f_shift_amt(input logic [7:0] r);
    logic [7:0] rm1;
    int         k;
    k   = 0;
    rm1 = r - 8'd1;
    if (r > 8'd1) begin
      for (int i = 0; i < 8; i++) begin
        if (rm1[i]) k = i + 1;
      end
    end
    if (k > log2_of_max_rate) k = log2_of_max_rate;
    return SW'((N-1)*k);
  endfunction

  // One guard bit above W so the rounding offset can never wrap before the clip.
  function automatic logic signed [W:0] f_round_shift(input logic signed [W-1:0] v,
                                                      input logic [SW-1:0]      sh);
    logic signed [W:0] ext;
`ifdef CIC_INTERP_ROUND_EN
    logic [W:0] half;
    half = '0;
    if (sh != '0) half[sh - SW'(1)] = 1'b1;
    ext = {v[W-1], v} + $signed(half);
`else
    ext = {v[W-1], v};
`endif
    return ext >>> sh;
  endfunction

  function automatic logic signed [bw-1:0] f_sat(input logic signed [W:0] v);
    if (v > SAT_MAX)      return SAT_MAX[bw-1:0];
    else if (v < SAT_MIN) return SAT_MIN[bw-1:0];
    else                  return v[bw-1:0];
  endfunction

  logic signed [W-1:0]  r_sampler;
  logic signed [W-1:0]  r_diff  [N];
  logic signed [W-1:0]  r_comb  [N];
  logic signed [W-1:0]  r_integ [N];
  logic                 r_pending;
  logic [SW-1:0]        r_shift;
  logic                 r_strobe_pipe_p1;
  logic signed [bw-1:0] r_signal_out_p2;
  logic                 r_vld_p2;

  logic signed [W-1:0]  w_signal_in_ext;
  logic signed [W-1:0]  w_integ_in;
  logic signed [W:0]    w_shifted;
  logic signed [bw-1:0] w_clipped;

  assign w_signal_in_ext = {{(W-bw){signal_in[bw-1]}}, signal_in};
  assign w_integ_in      = r_pending ? r_comb[N-1] : '0;
  assign w_shifted       = f_round_shift(r_integ[N-1], r_shift);
  assign w_clipped       = f_sat(w_shifted);

  // Stage p0: comb section at the input rate
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_sampler <= '0;
      r_shift   <= '0;
      for (int i = 0; i < N; i++) begin
        r_diff[i] <= '0;
        r_comb[i] <= '0;
      end
    end else if (!enable) begin
      r_sampler <= '0;
      r_shift   <= '0;
      for (int i = 0; i < N; i++) begin
        r_diff[i] <= '0;
        r_comb[i] <= '0;
      end
    end else if (strobe_in) begin
      r_sampler <= w_signal_in_ext;
      r_shift   <= f_shift_amt(rate);
      r_diff[0] <= r_sampler;
      r_comb[0] <= r_sampler - r_diff[0];
      for (int i = 1; i < N; i++) begin
        r_diff[i] <= r_comb[i-1];
        r_comb[i] <= r_comb[i-1] - r_diff[i];
      end
    end
  end

  // Stage p0: integrators at the output rate; a coincident strobe_in re-arms pending
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_pending <= 1'b0;
      for (int i = 0; i < N; i++) r_integ[i] <= '0;
    end else if (!enable) begin
      r_pending <= 1'b0;
      for (int i = 0; i < N; i++) r_integ[i] <= '0;
    end else begin
      if (strobe_out) begin
        r_integ[0] <= r_integ[0] + w_integ_in;
        for (int i = 1; i < N; i++) r_integ[i] <= r_integ[i] + r_integ[i-1];
      end
      if (strobe_in)       r_pending <= 1'b1;
      else if (strobe_out) r_pending <= 1'b0;
    end
  end

  // Stage p1 -> p2: delayed strobe, renormalise and clip into the output register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_strobe_pipe_p1 <= 1'b0;
      r_vld_p2         <= 1'b0;
      r_signal_out_p2  <= '0;
    end else if (!enable) begin
      r_strobe_pipe_p1 <= 1'b0;
      r_vld_p2         <= 1'b0;
      r_signal_out_p2  <= '0;
    end else begin
      r_strobe_pipe_p1 <= strobe_out;
      r_vld_p2         <= r_strobe_pipe_p1;
      if (r_strobe_pipe_p1) r_signal_out_p2 <= w_clipped;
    end
  end

  assign signal_out   = r_signal_out_p2;
  assign strobe_valid = r_vld_p2;

endmodule
